// File: rtl/mac_pkg.sv
// Shared constants and types for the pipelined multiply-add / accumulate unit.
package mac_pkg;

  localparam int SIZE    = 8;   // operand width of A, B, C
  localparam int OUTSIZE = 20;  // result width, at least 2*SIZE+1
  localparam int LENW    = 4;   // width of the accumulate block length

  typedef enum logic {
    MODE_MADD = 1'b0,
    MODE_ACC  = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  typedef logic [SIZE-1:0]    operand_t;
  typedef logic [OUTSIZE-1:0] result_t;

endpackage

// File: rtl/mac_accum_pipe_if.sv
// Sample-side and result-side valid/ready bus of the multiply-add unit.
interface mac_accum_pipe_if #(
  parameter int SIZE    = mac_pkg::SIZE,
  parameter int OUTSIZE = mac_pkg::OUTSIZE,
  parameter int LENW    = mac_pkg::LENW
);

  logic               in_valid;
  logic               in_ready;
  logic [SIZE-1:0]    A;
  logic [SIZE-1:0]    B;
  logic [SIZE-1:0]    C;
  logic               mode;
  logic [LENW-1:0]    acc_len;
  logic               out_valid;
  logic               out_ready;
  logic [OUTSIZE-1:0] data_out;
  logic               ovf;

  // Producer/consumer side: drives samples and accepts results.
  modport master (
    output in_valid, A, B, C, mode, acc_len, out_ready,
    input  in_ready, out_valid, data_out, ovf
  );

  // Unit side.
  modport slave (
    input  in_valid, A, B, C, mode, acc_len, out_ready,
    output in_ready, out_valid, data_out, ovf
  );

endinterface

// File: rtl/mac_sat_add.sv
// Combinational unsigned adder that clamps to all-ones on carry-out.
module mac_sat_add #(
  parameter int W = mac_pkg::OUTSIZE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = ovf ? '1 : full[W-1:0];

endmodule

// File: rtl/mac_accum_pipe.sv
// Two-stage multiply-add unit: stage 1 registers A*B, stage 2 either emits
// A*B+C per sample or sums a block of products, saturating in both cases.
module mac_accum_pipe #(
  parameter int SIZE    = mac_pkg::SIZE,
  parameter int OUTSIZE = mac_pkg::OUTSIZE,
  parameter int LENW    = mac_pkg::LENW
) (
  input logic             clc,
  input logic             rst,
  mac_accum_pipe_if.slave bus
);
  import mac_pkg::*;

  localparam int PW = 2 * SIZE;

  // Whole pipeline advances together; a stalled result freezes everything.
  logic en;

  logic            s1_v_reg;
  logic [PW-1:0]   s1_prod_reg;
  logic [SIZE-1:0] s1_c_reg;
  mode_t           s1_mode_reg;
  logic [LENW-1:0] s1_len_reg;

  state_t             state_reg, state_next;
  logic [OUTSIZE-1:0] acc_reg, acc_next;
  logic [LENW-1:0]    count_reg, count_next;
  logic [LENW-1:0]    len_reg, len_next;
  logic               ovf_acc_reg, ovf_acc_next;
  logic               out_valid_reg, out_valid_next;
  logic [OUTSIZE-1:0] data_reg, data_next;
  logic               ovf_reg, ovf_next;

  logic [OUTSIZE-1:0] prod_ext;
  logic [OUTSIZE-1:0] add_a;
  logic [OUTSIZE-1:0] add_sum;
  logic               add_ovf;
  logic [LENW-1:0]    count_inc;
  logic [LENW-1:0]    len_eff;

  assign en            = !out_valid_reg || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_reg;
  assign bus.data_out  = data_reg;
  assign bus.ovf       = ovf_reg;

  assign prod_ext  = OUTSIZE'(s1_prod_reg);
  assign count_inc = count_reg + LENW'(1);
  // A zero block length would never close, so it behaves as a length of one.
  assign len_eff   = (s1_len_reg == '0) ? LENW'(1) : s1_len_reg;

  // One adder serves both paths: addend C in MADD, running sum in ACC.
  assign add_a = (state_reg == ST_ACC) ? acc_reg : OUTSIZE'(s1_c_reg);

  mac_sat_add #(.W(OUTSIZE)) u_add (
    .a   (add_a),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Stage 1: capture the product and the per-sample controls.
  always_ff @(posedge clc) begin
    if (rst) begin
      s1_v_reg    <= 1'b0;
      s1_prod_reg <= '0;
      s1_c_reg    <= '0;
      s1_mode_reg <= MODE_MADD;
      s1_len_reg  <= '0;
    end else if (en) begin
      s1_v_reg    <= bus.in_valid;
      s1_prod_reg <= PW'(bus.A) * PW'(bus.B);
      s1_c_reg    <= bus.C;
      s1_mode_reg <= mode_t'(bus.mode);
      s1_len_reg  <= bus.acc_len;
    end
  end

  // Stage 2 next-state: MADD result, block open, accumulate or block close.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    len_next       = len_reg;
    ovf_acc_next   = ovf_acc_reg;
    out_valid_next = 1'b0;
    data_next      = data_reg;
    ovf_next       = ovf_reg;
    if (s1_v_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (s1_mode_reg == MODE_ACC) begin
            len_next     = len_eff;
            acc_next     = prod_ext;
            count_next   = LENW'(1);
            ovf_acc_next = 1'b0;
            if (len_eff == LENW'(1)) begin
              out_valid_next = 1'b1;
              data_next      = prod_ext;
              ovf_next       = 1'b0;
            end else begin
              state_next = ST_ACC;
            end
          end else begin
            out_valid_next = 1'b1;
            data_next      = add_sum;
            ovf_next       = add_ovf;
          end
        end
        ST_ACC: begin
          // Mode/acc_len carried by samples inside an open block are ignored.
          acc_next     = add_sum;
          ovf_acc_next = ovf_acc_reg | add_ovf;
          count_next   = count_inc;
          if (count_inc == len_reg) begin
            out_valid_next = 1'b1;
            data_next      = add_sum;
            ovf_next       = ovf_acc_reg | add_ovf;
            state_next     = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Stage 2 registers; reset discards any partially accumulated block.
  always_ff @(posedge clc) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      len_reg       <= '0;
      ovf_acc_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      data_reg      <= '0;
      ovf_reg       <= 1'b0;
    end else if (en) begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      len_reg       <= len_next;
      ovf_acc_reg   <= ovf_acc_next;
      out_valid_reg <= out_valid_next;
      data_reg      <= data_next;
      ovf_reg       <= ovf_next;
    end
  end

endmodule

// File: tb/tb_mac_accum_pipe.sv
// Scoreboard bench for mac_accum_pipe: expected results are queued when the
// closing sample is driven and compared when a result transfers.
module tb_mac_accum_pipe;
  import mac_pkg::*;

  localparam int TSIZE = 8;
  localparam int TOUT  = 17;
  localparam int TLEN  = 4;
  localparam int MAXV  = (1 << TOUT) - 1;

  logic clc = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clc = ~clc;
  always @(posedge clc) cyc++;

  mac_accum_pipe_if #(.SIZE(TSIZE), .OUTSIZE(TOUT), .LENW(TLEN)) bus ();

  mac_accum_pipe #(.SIZE(TSIZE), .OUTSIZE(TOUT), .LENW(TLEN)) dut (
    .clc (clc),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [TOUT-1:0] data;
    logic            ovf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Result monitor: every transfer must match the head of the scoreboard.
  always @(negedge clc) begin
    exp_t e;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result: got data_out=%0d ovf=%0d, required no result", bus.data_out, bus.ovf);
      end else begin
        e = sb_q.pop_front();
        if (bus.data_out !== e.data || bus.ovf !== e.ovf) begin
          miscompares++;
          $display("FAIL result: got data_out=%0d ovf=%0d, required data_out=%0d ovf=%0d", bus.data_out, bus.ovf, e.data, e.ovf);
        end else begin
          $display("result data_out=%0d ovf=%0d ok", bus.data_out, bus.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input int val, input bit o);
    exp_t e;
    e.data = TOUT'(val);
    e.ovf  = o;
    sb_q.push_back(e);
  endtask

  // Present one sample and hold it until it is accepted.
  task automatic send(input int a, input int b, input int c, input bit m, input int len);
    int n = 0;
    bus.A        = a[TSIZE-1:0];
    bus.B        = b[TSIZE-1:0];
    bus.C        = c[TSIZE-1:0];
    bus.mode     = m;
    bus.acc_len  = len[TLEN-1:0];
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clc); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL send_accept: got in_ready=%b for 50 cycles, required 1", bus.in_ready);
    end
    @(posedge clc); #1;
    bus.in_valid = 1'b0;
    $display("sample A=%0d B=%0d C=%0d mode=%0d acc_len=%0d accepted", a, b, c, m, len);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clc); #1;
      n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(posedge clc);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clc);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    vectors++;
    if (bus.data_out !== '0) begin miscompares++; $display("FAIL reset_data_out: got %0d, required 0", bus.data_out); end
    vectors++;
    if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b, required 0", bus.ovf); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    rst = 1'b0;
    @(posedge clc); #1;
  endtask

  task automatic test_madd();
    bus.out_ready = 1'b1;
    push_exp(3 * 4 + 5, 1'b0);
    send(3, 4, 5, 1'b0, 0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL madd_latency_early: got out_valid=%b, required 0", bus.out_valid); end
    @(posedge clc); #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.data_out !== TOUT'(17)) begin
      miscompares++;
      $display("FAIL madd_latency: got out_valid=%b data_out=%0d, required 1 and 17", bus.out_valid, bus.data_out);
    end
    push_exp(255 * 255 + 255, 1'b0);
    send(255, 255, 255, 1'b0, 0);
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL madd_in_ready: got %b, required 1", bus.in_ready); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int t0;
    bus.out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %b, required 1", bus.in_ready); end
      push_exp((i + 1) * (i + 2) + i * 10, 1'b0);
      send(i + 1, i + 2, i * 10, 1'b0, 0);
    end
    vectors++;
    if (cyc - t0 !== 4) begin miscompares++; $display("FAIL b2b_throughput: got %0d cycles for 4 samples, required 4", cyc - t0); end
    wait_drain();
  endtask

  task automatic test_acc();
    int pa[4] = '{2, 4, 1, 10};
    int pb[4] = '{3, 5, 1, 10};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push_exp(2 * 3 + 4 * 5 + 1 * 1 + 10 * 10, 1'b0);
      send(pa[i], pb[i], 99, 1'b1, 4);
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    longint s = 3 * 255 * 255;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) push_exp((s > MAXV) ? MAXV : int'(s), s > MAXV);
      send(255, 255, 0, 1'b1, 3);
    end
    push_exp(1, 1'b0);
    send(1, 1, 0, 1'b1, 1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    push_exp(17, 1'b0);
    send(3, 4, 5, 1'b0, 0);
    @(posedge clc); #1;
    push_exp(2 * 2 + 2, 1'b0);
    bus.A = 8'd2; bus.B = 8'd2; bus.C = 8'd2; bus.mode = 1'b0; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.data_out !== TOUT'(17)) begin
        miscompares++;
        $display("FAIL stall_hold: got in_ready=%b out_valid=%b data_out=%0d, required 0 1 17", bus.in_ready, bus.out_valid, bus.data_out);
      end
      @(posedge clc); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clc); #1;
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_block();
    bus.out_ready = 1'b1;
    send(3, 3, 0, 1'b1, 5);
    send(4, 4, 0, 1'b1, 5);
    rst = 1'b1;
    @(posedge clc); #1;
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got out_valid=%b data_out=%0d, required 0 0", bus.out_valid, bus.data_out);
    end
    push_exp(7, 1'b0);
    send(1, 7, 0, 1'b1, 1);
    wait_drain();
  endtask

  task automatic test_len0_mode_change();
    bus.out_ready = 1'b1;
    push_exp(81, 1'b0);
    send(9, 9, 0, 1'b1, 0);
    wait_drain();
    send(5, 6, 0, 1'b1, 2);
    push_exp(5 * 6 + 7 * 8, 1'b0);
    send(7, 8, 100, 1'b0, 9);
    push_exp(2 * 3 + 4, 1'b0);
    send(2, 3, 4, 1'b0, 0);
    wait_drain();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.C         = '0;
    bus.mode      = 1'b0;
    bus.acc_len   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    test_reset();
    test_madd();
    test_back_to_back();
    test_acc();
    test_saturation();
    test_backpressure();
    test_reset_mid_block();
    test_len0_mode_change();
    repeat (5) @(posedge clc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
